// File: rtl/note_lane_engine.sv
// note_lane_engine: falling-note engine for the rhythm game.
// Holds up to SLOTS notes across LANES columns. Notes fall one pixel per
// TICK_DIV clocks. Key presses are judged against the lowest untried note in
// the hit window. The engine keeps score and combo and drives per-lane sprite
// enables for the VGA pixel stage.
// Optional build macro: GHOST_PENALTY_EN. When it is defined, a press that has
// no target note counts as a miss.
module note_lane_engine #(
    parameter int LANES    = 4,
    parameter int SLOTS    = 4,
    parameter int TICK_DIV = 200000,
    parameter int Y_MAX    = 480,
    parameter int HIT_LO   = 420,
    parameter int HIT_HI   = 452,
    parameter int PERF_LO  = 430,
    parameter int PERF_HI  = 442,
    parameter int HALF_H   = 15,
    parameter int LANE_W   = 160
) (
    input  logic             CLOCK_25,
    input  logic             reset,
    input  logic [LANES-1:0] KEY,
    input  logic             spawn_valid,
    input  logic [LANES-1:0] spawn_pattern,
    output logic             spawn_ready,
    input  logic [9:0]       next_x,
    input  logic [9:0]       next_y,
    output logic [LANES-1:0] sprite_pattern,
    output logic             hit_pulse,
    output logic             perfect,
    output logic             miss_pulse,
    output logic [15:0]      score,
    output logic [7:0]       combo,
    output logic             busy
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]  Y_MAX_Y   = 10'(Y_MAX);
    localparam logic [9:0]  HIT_LO_Y  = 10'(HIT_LO);
    localparam logic [9:0]  HIT_HI_Y  = 10'(HIT_HI);
    localparam logic [9:0]  PERF_LO_Y = 10'(PERF_LO);
    localparam logic [9:0]  PERF_HI_Y = 10'(PERF_HI);
    localparam logic [10:0] HALF_H_W  = 11'(HALF_H);

    // Slot storage
    logic [SLOTS-1:0] valid_r;
    logic [SLOTS-1:0] tried_r;
    logic [LANES-1:0] pattern_r [SLOTS];
    logic [9:0]       y_r       [SLOTS];

    // Timing, key history and registered results
    logic [CNT_W-1:0] tick_cnt_r;
    logic [LANES-1:0] cmd_r;
    logic [LANES-1:0] cmd_prev_r;
    logic             hit_pulse_r;
    logic             perfect_r;
    logic             miss_pulse_r;
    logic [15:0]      score_r;
    logic [7:0]       combo_r;

    // Decode
    logic [LANES-1:0] lane_cmd_s;
    logic             tick_s;
    logic             press_s;
    logic             tgt_found_s;
    logic [IDX_W-1:0] tgt_idx_s;
    logic [9:0]       tgt_y_s;
    logic             in_perf_s;
    logic             judge_hit_s;
    logic             judge_bad_s;
    logic             ghost_s;
    logic             retire_miss_s;
    logic             miss_any_s;
    logic             free_found_s;
    logic [IDX_W-1:0] free_idx_s;
    logic             spawn_ok_s;
    logic [16:0]      score_sum_s;
    logic [15:0]      score_nxt_s;
    logic [7:0]       combo_nxt_s;
    logic [10:0]      slot_top_s [SLOTS];
    logic [10:0]      slot_bot_s [SLOTS];
    logic [LANES-1:0] sprite_s;

    // Map KEY into lane order (lane i sits on KEY[LANES-1-i]) so the pressed keys line up with note patterns
    always_comb begin
        lane_cmd_s = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_cmd_s[i] = ~KEY[LANES-1-i];
        end
    end

    // Pick the judge target: the lowest untried note in the hit window, with the lowest index on a tie
    always_comb begin
        tgt_found_s = 1'b0;
        tgt_idx_s   = '0;
        tgt_y_s     = 10'd0;
        for (int i = 0; i < SLOTS; i++) begin
            if (valid_r[i] && !tried_r[i] && (y_r[i] >= HIT_LO_Y) && (y_r[i] <= HIT_HI_Y)
                && (!tgt_found_s || (y_r[i] > tgt_y_s))) begin
                tgt_found_s = 1'b1;
                tgt_idx_s   = IDX_W'(i);
                tgt_y_s     = y_r[i];
            end else begin
                tgt_found_s = tgt_found_s;
            end
        end
    end

    // Find the lowest free slot for the next spawn
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Decide the tick, judge and retire results, then compute the next score and combo
    always_comb begin
        tick_s      = (tick_cnt_r == TICK_LAST);
        press_s     = |(cmd_r & ~cmd_prev_r);
        in_perf_s   = (tgt_y_s >= PERF_LO_Y) && (tgt_y_s <= PERF_HI_Y);
        judge_hit_s = press_s && tgt_found_s && (cmd_r == pattern_r[tgt_idx_s]);
        judge_bad_s = press_s && tgt_found_s && (cmd_r != pattern_r[tgt_idx_s]);
`ifdef GHOST_PENALTY_EN
        ghost_s     = press_s && !tgt_found_s;
`else
        ghost_s     = 1'b0;
`endif
        retire_miss_s = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (tick_s && valid_r[i] && (y_r[i] >= Y_MAX_Y) && !tried_r[i]) begin
                retire_miss_s = 1'b1;
            end else begin
                retire_miss_s = retire_miss_s;
            end
        end
        miss_any_s  = judge_bad_s || ghost_s || retire_miss_s;
        spawn_ok_s  = spawn_valid && spawn_ready;

        score_sum_s = {1'b0, score_r} + (in_perf_s ? 17'd2 : 17'd1);
        if (judge_hit_s) begin
            score_nxt_s = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
        end else begin
            score_nxt_s = score_r;
        end

        // A miss in the same cycle as a hit overrides the combo
        if (miss_any_s) begin
            combo_nxt_s = 8'd0;
        end else if (judge_hit_s) begin
            combo_nxt_s = (combo_r == 8'hFF) ? 8'hFF : combo_r + 8'd1;
        end else begin
            combo_nxt_s = combo_r;
        end
    end

    // Compute the vertical sprite extent of each slot in 11 bits so notes near the top do not wrap
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            slot_top_s[i] = ({1'b0, y_r[i]} > HALF_H_W) ? ({1'b0, y_r[i]} - HALF_H_W) : 11'd0;
            slot_bot_s[i] = {1'b0, y_r[i]} + HALF_H_W;
        end
    end

    // Build the per-lane draw enables for the current pixel
    always_comb begin
        sprite_s = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (valid_r[i] && pattern_r[i][l]
                    && ({1'b0, next_x} >= 11'(l * LANE_W))
                    && ({1'b0, next_x} <  11'((l + 1) * LANE_W))
                    && ({1'b0, next_y} >= slot_top_s[i])
                    && ({1'b0, next_y} <  slot_bot_s[i])) begin
                    sprite_s[l] = 1'b1;
                end else begin
                    sprite_s[l] = sprite_s[l];
                end
            end
        end
    end

    // Slot lifecycle: spawn into a free slot, fall on a tick, retire at the bottom, mark judged notes
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            valid_r <= '0;
            tried_r <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                pattern_r[i] <= '0;
                y_r[i]       <= 10'd0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (valid_r[i]) begin
                    if (tick_s && (y_r[i] >= Y_MAX_Y)) begin
                        valid_r[i] <= 1'b0;
                    end else if (tick_s) begin
                        y_r[i] <= y_r[i] + 10'd1;
                    end
                    if (press_s && tgt_found_s && (tgt_idx_s == IDX_W'(i))) begin
                        tried_r[i] <= 1'b1;
                    end
                end else if (spawn_ok_s && (free_idx_s == IDX_W'(i))) begin
                    valid_r[i]   <= 1'b1;
                    tried_r[i]   <= 1'b0;
                    pattern_r[i] <= spawn_pattern;
                    y_r[i]       <= 10'd0;
                end
            end
        end
    end

    // Tick divider, key history and registered judge outputs
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            tick_cnt_r   <= '0;
            cmd_r        <= '0;
            cmd_prev_r   <= '0;
            hit_pulse_r  <= 1'b0;
            perfect_r    <= 1'b0;
            miss_pulse_r <= 1'b0;
            score_r      <= 16'd0;
            combo_r      <= 8'd0;
        end else begin
            tick_cnt_r   <= tick_s ? '0 : tick_cnt_r + CNT_W'(1);
            cmd_r        <= lane_cmd_s;
            cmd_prev_r   <= cmd_r;
            hit_pulse_r  <= judge_hit_s;
            perfect_r    <= judge_hit_s && in_perf_s;
            miss_pulse_r <= miss_any_s;
            score_r      <= score_nxt_s;
            combo_r      <= combo_nxt_s;
        end
    end

    assign spawn_ready    = !reset && free_found_s;
    assign busy           = |valid_r;
    assign sprite_pattern = sprite_s;
    assign hit_pulse      = hit_pulse_r;
    assign perfect        = perfect_r;
    assign miss_pulse     = miss_pulse_r;
    assign score          = score_r;
    assign combo          = combo_r;

endmodule

// File: tb/tb_note_lane_engine.sv
// Testbench for note_lane_engine with a fast tick (TICK_DIV = 4).
// A note-level reference model is compared against the DUT on every cycle.
// Directed scenarios add literal expectations.
module tb_note_lane_engine;

    localparam int TDIV = 4;
`ifdef GHOST_PENALTY_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] KEY;
    logic       spawn_valid;
    logic [3:0] spawn_pattern;
    logic       spawn_ready;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic [3:0] sprite_pattern;
    logic       hit_pulse;
    logic       perfect;
    logic       miss_pulse;
    logic [15:0] score;
    logic [7:0] combo;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    note_lane_engine #(.TICK_DIV(TDIV)) dut (
        .CLOCK_25(clk), .reset(reset), .KEY(KEY),
        .spawn_valid(spawn_valid), .spawn_pattern(spawn_pattern), .spawn_ready(spawn_ready),
        .next_x(next_x), .next_y(next_y), .sprite_pattern(sprite_pattern),
        .hit_pulse(hit_pulse), .perfect(perfect), .miss_pulse(miss_pulse),
        .score(score), .combo(combo), .busy(busy)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (note list) ----------------
    bit         m_v [4];
    bit         m_t [4];
    logic [3:0] m_p [4];
    int         m_y [4];
    int         m_cnt;
    logic [3:0] m_cmd, m_cmdp;
    bit         m_hit, m_perf, m_miss;
    int         m_score, m_combo;

    always @(posedge clk) begin : model
        int tgt, fs, add;
        bit press, tick, good, bad, ghost, rmiss, pf;
        logic [3:0] lane_cmd;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_v[i] <= 1'b0; m_t[i] <= 1'b0; m_p[i] <= 4'd0; m_y[i] <= 0;
            end
            m_cnt <= 0; m_cmd <= 4'd0; m_cmdp <= 4'd0;
            m_hit <= 1'b0; m_perf <= 1'b0; m_miss <= 1'b0;
            m_score <= 0; m_combo <= 0;
        end else begin
            for (int l = 0; l < 4; l++) lane_cmd[l] = ~KEY[3-l];
            press = ((m_cmd & ~m_cmdp) != 4'd0);
            tick  = (m_cnt == TDIV - 1);
            tgt = -1;
            for (int i = 0; i < 4; i++)
                if (m_v[i] && !m_t[i] && m_y[i] >= 420 && m_y[i] <= 452)
                    if (tgt < 0 || m_y[i] > m_y[tgt]) tgt = i;
            good  = press && (tgt >= 0) && (m_cmd == m_p[tgt >= 0 ? tgt : 0]);
            bad   = press && (tgt >= 0) && !good;
            ghost = press && (tgt < 0) && GHOST;
            pf    = (tgt >= 0) && m_y[tgt >= 0 ? tgt : 0] >= 430 && m_y[tgt >= 0 ? tgt : 0] <= 442;
            fs = -1;
            for (int i = 0; i < 4; i++) if (!m_v[i] && fs < 0) fs = i;
            rmiss = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (m_v[i] && tick) begin
                    if (m_y[i] >= 480) begin
                        m_v[i] <= 1'b0;
                        if (!m_t[i]) rmiss = 1'b1;
                    end else begin
                        m_y[i] <= m_y[i] + 1;
                    end
                end
            end
            if (press && tgt >= 0) m_t[tgt] <= 1'b1;
            if (spawn_valid && fs >= 0) begin
                m_v[fs] <= 1'b1; m_t[fs] <= 1'b0; m_p[fs] <= spawn_pattern; m_y[fs] <= 0;
            end
            m_cnt  <= tick ? 0 : m_cnt + 1;
            m_cmd  <= lane_cmd;
            m_cmdp <= m_cmd;
            m_hit  <= good;
            m_perf <= good && pf;
            m_miss <= bad || ghost || rmiss;
            add = pf ? 2 : 1;
            if (good) m_score <= (m_score + add > 65535) ? 65535 : m_score + add;
            if (bad || ghost || rmiss) m_combo <= 0;
            else if (good) m_combo <= (m_combo >= 255) ? 255 : m_combo + 1;
        end
    end

    function automatic logic [3:0] model_sprite(input int nx, input int ny);
        logic [3:0] r;
        int top;
        r = 4'd0;
        for (int l = 0; l < 4; l++)
            for (int i = 0; i < 4; i++) begin
                top = (m_y[i] > 15) ? m_y[i] - 15 : 0;
                if (m_v[i] && m_p[i][l] && nx >= l * 160 && nx < (l + 1) * 160
                    && ny >= top && ny < m_y[i] + 15) r[l] = 1'b1;
            end
        return r;
    endfunction

    // Compare the DUT against the model on every falling edge
    always @(negedge clk) begin : cmp
        bit any_free, any_valid;
        any_free = 1'b0; any_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!m_v[i]) any_free = 1'b1;
            if (m_v[i]) any_valid = 1'b1;
        end
        chk("m_hit_pulse", hit_pulse, m_hit);
        chk("m_perfect", perfect, m_perf);
        chk("m_miss_pulse", miss_pulse, m_miss);
        chk("m_score", score, m_score);
        chk("m_combo", combo, m_combo);
        chk("m_busy", busy, any_valid);
        chk("m_spawn_ready", spawn_ready, !reset && any_free);
        chk("m_sprite", sprite_pattern, model_sprite(next_x, next_y));
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [3:0] lanes);
        for (int l = 0; l < 4; l++) KEY[3-l] = ~lanes[l];
    endtask

    task automatic release_keys();
        @(posedge clk); #1;
        KEY = 4'b1111;
    endtask

    task automatic spawn(input logic [3:0] pat);
        spawn_valid = 1'b1; spawn_pattern = pat;
        @(posedge clk); #1;
        spawn_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_y(input int s, input int y, input string name);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (m_v[s] && m_y[s] == y) break;
        end
        chk(name, m_y[s], y);
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!(m_v[0] || m_v[1] || m_v[2] || m_v[3])) break;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic after_press();
        @(posedge clk); @(posedge clk); @(negedge clk);
    endtask

    initial begin
        KEY = 4'b1111; spawn_valid = 1'b0; spawn_pattern = 4'd0;
        next_x = 10'd0; next_y = 10'd0; reset = 1'b1;
        @(negedge clk);
        chk("rst_spawn_ready", spawn_ready, 1'b0);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First note, hit at y=420 (outside the perfect window)
        spawn(4'b0001);
        chk("s1_busy", busy, 1'b1);
        wait_y(0, 420, "s1_y420");
        press(4'b0001);
        after_press();
        chk("s1_hit", hit_pulse, 1'b1);
        chk("s1_perfect", perfect, 1'b0);
        chk("s1_score", score, 1);
        chk("s1_combo", combo, 1);
        release_keys();

        // Two-lane chord hit in the perfect window, then a wrong press on a trailing note
        spawn(4'b0101);               // slot1
        step(40);
        spawn(4'b0101);               // slot2, ten ticks behind
        wait_y(1, 435, "s2_y435");
        press(4'b0101);
        after_press();
        chk("s2_hit", hit_pulse, 1'b1);
        chk("s2_perfect", perfect, 1'b1);
        chk("s2_score", score, 3);
        chk("s2_combo", combo, 2);
        release_keys();
        step(1);
        press(4'b0001);
        after_press();
        chk("s2_wrong_miss", miss_pulse, 1'b1);
        chk("s2_wrong_hit", hit_pulse, 1'b0);
        chk("s2_wrong_combo", combo, 0);
        chk("s2_wrong_score", score, 3);
        release_keys();
        wait_idle("s2_idle");

        // Fill all slots, hold spawn_valid, then refill a slot after an unhit retire
        for (int k = 0; k < 4; k++) begin
            spawn(4'b0001);
            if (k < 3) step(40);
        end
        spawn_valid = 1'b1; spawn_pattern = 4'b1000;
        @(negedge clk);
        chk("s3_full_ready", spawn_ready, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (!m_v[0]) break;
        end
        chk("s3_retire_miss", miss_pulse, 1'b1);
        chk("s3_ready_after", spawn_ready, 1'b1);
        chk("s3_combo", combo, 0);
        @(posedge clk); #1;
        spawn_valid = 1'b0;
        chk("s3_slot0_loaded", m_v[0] && m_y[0] == 0, 1'b1);
        next_x = 10'd500; next_y = 10'd3;
        #1;
        chk("s3_new_sprite", sprite_pattern, 4'b1000);
        wait_idle("s3_idle");

        // Two notes at 440 and 425: the lower one is judged first
        spawn(4'b0011);               // slot0
        step(60);
        spawn(4'b0011);               // slot1
        wait_y(0, 440, "s4_y440");
        press(4'b0011);
        after_press();
        chk("s4_first_hit", hit_pulse, 1'b1);
        chk("s4_first_perfect", perfect, 1'b1);
        chk("s4_first_score", score, 5);
        release_keys();
        step(1);
        press(4'b0011);
        after_press();
        chk("s4_second_hit", hit_pulse, 1'b1);
        chk("s4_second_perfect", perfect, 1'b0);
        chk("s4_second_score", score, 6);
        chk("s4_second_combo", combo, 2);
        release_keys();
        wait_idle("s4_idle");

        // Ghost press with no notes in flight
        step(1);
        press(4'b0001);
        after_press();
`ifdef GHOST_PENALTY_EN
        chk("ghost_miss", miss_pulse, 1'b1);
        chk("ghost_combo", combo, 0);
`else
        chk("ghost_miss", miss_pulse, 1'b0);
        chk("ghost_combo", combo, 2);
`endif
        chk("ghost_score", score, 6);
        release_keys();

        // Sprite extent of a note at y=5 in lane 1
        spawn(4'b0010);
        wait_y(0, 5, "s6_y5");
        next_x = 10'd170;
        for (int yy = 0; yy <= 20; yy++) begin
            next_y = 10'(yy);
            #2;
            chk("s6_sprite_y", sprite_pattern, (yy < 20) ? 4'b0010 : 4'b0000);
        end
        next_x = 10'd150; next_y = 10'd5;
        #1;
        chk("s6_sprite_lane0", sprite_pattern, 4'b0000);

        // Mid-run reset drops a pending hit
        wait_y(0, 430, "s7_y430");
        next_x = 10'd170; next_y = 10'd430;
        press(4'b0010);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s7_hit", hit_pulse, 1'b0);
        chk("s7_perfect", perfect, 1'b0);
        chk("s7_miss", miss_pulse, 1'b0);
        chk("s7_score", score, 0);
        chk("s7_combo", combo, 0);
        chk("s7_busy", busy, 1'b0);
        chk("s7_ready", spawn_ready, 1'b0);
        chk("s7_sprite", sprite_pattern, 4'b0000);
        KEY = 4'b1111;
        @(posedge clk); #1;
        reset = 1'b0;
        step(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
